module_spi_master_ctrl: RTL and testbench
=========================================

MODULE_SPI_MASTER_CTRL -- requirements
Module: module_spi_master_ctrl

Interface
REQ-001 Parameter N, default 2: register-file address width.
REQ-002 Parameter DATA_WIDTH, default 32: register-file word width.
REQ-003 Parameter CLK_DIV, default 2, minimum 1: clk_i cycles per SCLK half-period.
REQ-004 Single clock and reset; the reset is synchronous and active-high. Both are named as below:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_i  in  1  reset, synchronous to clk_i, active-high.
REQ-005 Port list:
- start_i  in  1  one-cycle request to start a burst.
- n_tx_i  in  N  index of the last word in the burst; the burst covers addresses 0..n_tx_i.
- data_i  in  DATA_WIDTH  register-file read data for addr_o, combinational.
- addr_o  out  N  register-file address, used for both read and write.
- wr_o  out  1  register-file write strobe.
- data_o  out  DATA_WIDTH  write-back word.
- hold_ctrl_o  out  1  high while a burst is active; blocks host writes.
- busy_o  out  1  a burst is in progress.
- done_o  out  1  one-cycle pulse at the end of a burst.
- sclk_o  out  1  SPI clock, idle low (mode 0).
- mosi_o  out  1  serial data out, MSB first.
- miso_i  in  1  serial data in.
- cs_n_o  out  1  chip select, active-low.

Function
REQ-006 FSM states are IDLE, LOAD, SHIFT, WRITEBACK and DONE.
REQ-007 IDLE: when start_i=1, latch n_tx_i, set addr_o=0, busy_o=1, hold_ctrl_o=1 and cs_n_o=0, then go to LOAD. start_i is ignored in every state other than IDLE.
REQ-008 LOAD, 1 cycle: capture data_i[7:0] into an 8-bit TX shift register and clear the RX register, then go to SHIFT.
REQ-009 SHIFT lasts exactly 16*CLK_DIV cycles and carries 8 bits, MSB first.
- sclk_o toggles every CLK_DIV cycles, starting low.
- mosi_o = TX[7] throughout SHIFT.
- On each sclk rising transition, sample miso_i into RX[0] after shifting RX left.
- On each sclk falling transition, shift TX left.
- sclk_o returns low at the end of SHIFT.
REQ-010 WRITEBACK, 1 cycle:
- wr_o=1, with addr_o unchanged.
- data_o = RX zero-extended to DATA_WIDTH.
- If addr_o == the latched n_tx, go to DONE; otherwise increment addr_o and go to LOAD.
REQ-011 cs_n_o stays low continuously across all words of a burst; SCLK does not run between words other than in SHIFT.
REQ-012 DONE, 1 cycle:
- done_o=1; cs_n_o=1; busy_o=0; hold_ctrl_o=0.
- Then go to IDLE.
REQ-013 Burst latency from the start_i sampling edge to the done_o cycle is (n_tx+1)*(2+16*CLK_DIV) cycles; done_o is high in the cycle after the last WRITEBACK.
REQ-014 Outside WRITEBACK: wr_o=0 and data_o holds its last value. Outside SHIFT: mosi_o=0.
REQ-015 n_tx_i=0 is a legal one-word burst. n_tx_i=2**N-1 transfers every address with no wrap-around.

Reset
REQ-016 When rst_i=1 at a clock edge, the following apply on the next cycle:
- State = IDLE.
- sclk_o=0, mosi_o=0, cs_n_o=1.
- wr_o=0, data_o=0, addr_o=0.
- busy_o=0, hold_ctrl_o=0, done_o=0.
- TX, RX and divider counters are cleared.
REQ-017 A reset in the middle of a burst aborts it immediately: no write-back and no done_o pulse.

Structure
REQ-018 A shared package spi_pkg contains:
- the FSM state enum;
- FRAME_BITS=8;
- default DATA_WIDTH and N.
REQ-019 SCLK half-period timing lives in the sub-module module_spi_clk_gen.
- Inputs: en, CLK_DIV.
- Outputs: sclk level, rise strobe, fall strobe, last-edge flag.
REQ-020 The implementation totals roughly 150-300 lines of RTL.

Verification
REQ-021 Loopback (mosi_o wired to miso_i), CLK_DIV=2, word[0]='h25, start with n_tx=0 -> one wr_o pulse writing addr 0 with 'h00000025; done_o high exactly 34 cycles after start; exactly 8 sclk rising edges.
REQ-022 miso_i tied to 1, n_tx=1, words 'h12 and 'h34 -> mosi_o bit sequence 00010010 then 00110100; writes of 'hFF to addr 0 then addr 1; cs_n_o low for the whole burst.
REQ-023 n_tx=3 -> four write-backs at addresses 0,1,2,3 in order; addr_o does not wrap; done_o high exactly once.
REQ-024 start_i pulsed again during SHIFT -> ignored; the burst length is unchanged.
REQ-025 rst_i asserted during the fifth bit -> next cycle cs_n_o=1, sclk_o=0, busy_o=0, hold_ctrl_o=0; no wr_o and no done_o.
REQ-026 CLK_DIV=1, n_tx=0 -> sclk_o period of 2 cycles; done_o at cycle 18 after start.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI burst master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int FRAME_BITS       = 8;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_N            = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/module_spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : module_spi_clk_gen
// Description : SCLK half-period divider for one 8-bit frame. Produces the
//               SCLK level plus rise/fall strobes that fire in the cycle
//               before the level changes, and a flag on the final fall.
// Revision    : 1.0 - initial release
// ============================================================================
module module_spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o,
    output logic last_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(2 * FRAME_BITS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] half_q, half_d;
    logic          sclk_q, sclk_d;
    logic          tick;

    assign tick   = (cnt_q == CW'(CLK_DIV - 1));
    assign sclk_o = sclk_q;
    assign rise_o = en_i & tick & ~sclk_q;
    assign fall_o = en_i & tick & sclk_q;
    assign last_o = fall_o & (half_q == HW'(2 * FRAME_BITS - 1));

    // Divider: count CLK_DIV cycles per half period; idle low when disabled.
    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            half_d = '0;
            sclk_d = 1'b0;
        end else if (tick) begin
            cnt_d  = '0;
            half_d = half_q + 1'b1;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            half_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            sclk_q <= sclk_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/module_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : module_spi_master_ctrl
// Description : SPI mode-0 burst master. Reads words 0..n_tx from a register
//               file, shifts the low byte out MSB first, and writes the
//               received byte back to the same address.
// Revision    : 1.0 - initial release
// ============================================================================
module module_spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [N-1:0]          n_tx_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [N-1:0]          addr_o,
    output logic                  wr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  hold_ctrl_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    input  logic                  miso_i,
    output logic                  cs_n_o
);

    state_e                  state_q, state_d;
    logic [N-1:0]            addr_q, addr_d;
    logic [N-1:0]            ntx_q, ntx_d;
    logic [FRAME_BITS-1:0]   tx_q, tx_d;
    logic [FRAME_BITS-1:0]   rx_q, rx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    sck_rise, sck_fall, sck_last, sck_en;
    logic                    active;

    generate
        if (DATA_WIDTH > FRAME_BITS) begin : g_unused_hi
            logic unused_data_hi;
            assign unused_data_hi = ^data_i[DATA_WIDTH-1:FRAME_BITS];
        end
    endgenerate

    assign sck_en = (state_q == ST_SHIFT);

    module_spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (sck_en),
        .sclk_o  (sclk_o),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall),
        .last_o  (sck_last)
    );

    // Chip select and busy cover every word; the DONE cycle already releases them.
    assign active      = (state_q == ST_LOAD) || (state_q == ST_SHIFT) ||
                         (state_q == ST_WRITEBACK);
    assign busy_o      = active;
    assign hold_ctrl_o = active;
    assign cs_n_o      = ~active;
    assign wr_o        = (state_q == ST_WRITEBACK);
    assign done_o      = (state_q == ST_DONE);
    assign mosi_o      = sck_en & tx_q[FRAME_BITS-1];
    assign addr_o      = addr_q;
    assign data_o      = data_q;

    // Next-state and datapath: one byte per word, write-back, then next address.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ntx_d   = ntx_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    ntx_d   = n_tx_i;
                    addr_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_d    = data_i[FRAME_BITS-1:0];
                rx_d    = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    rx_d = {rx_q[FRAME_BITS-2:0], miso_i};
                end
                if (sck_fall) begin
                    tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                end
                // The final edge is a fall, so RX is complete here.
                if (sck_last) begin
                    data_d  = DATA_WIDTH'(rx_q);
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                if (addr_q == ntx_q) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ntx_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ntx_q   <= ntx_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_module_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_module_spi_master_ctrl
// Description : Self-checking bench for the SPI burst master: a cycle-level
//               model derived from the burst timing rules plus directed
//               scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_module_spi_master_ctrl;

    localparam int D = 2;
    localparam int P = 2 + 16 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  ntx = '0;
    logic [31:0] data_i;
    logic [1:0]  addr;
    logic        wr, busy, hold, done, sclk, mosi, miso, cs_n;
    logic [31:0] data_o;
    int          miso_mode = 0;
    logic        miso_rand = 1'b0;
    logic [31:0] mem [4];

    // second instance, CLK_DIV = 1, loopback
    logic        rst1 = 1'b1;
    logic        start1 = 1'b0;
    logic [1:0]  addr1;
    logic [31:0] data_o1;
    logic        wr1, busy1, hold1, done1, sclk1, mosi1, cs_n1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign miso   = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 : miso_rand;
    assign data_i = mem[addr];

    module_spi_master_ctrl #(.N(2), .DATA_WIDTH(32), .CLK_DIV(D)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .n_tx_i(ntx), .data_i(data_i),
        .addr_o(addr), .wr_o(wr), .data_o(data_o), .hold_ctrl_o(hold),
        .busy_o(busy), .done_o(done), .sclk_o(sclk), .mosi_o(mosi),
        .miso_i(miso), .cs_n_o(cs_n)
    );

    module_spi_master_ctrl #(.N(2), .DATA_WIDTH(32), .CLK_DIV(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .start_i(start1), .n_tx_i(2'd0), .data_i(mem[addr1]),
        .addr_o(addr1), .wr_o(wr1), .data_o(data_o1), .hold_ctrl_o(hold1),
        .busy_o(busy1), .done_o(done1), .sclk_o(sclk1), .mosi_o(mosi1),
        .miso_i(mosi1), .cs_n_o(cs_n1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        miso_rand = 1'($urandom_range(0, 1));
    end

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    int          t0 = 0;
    bit          chk_en = 0;
    bit          m_act = 0;
    int          m_c = 0;
    int          m_n = 0;
    logic [7:0]  m_word = '0;
    logic [7:0]  m_rx = '0;
    logic [1:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic        miso_s = 1'b0;

    always @(negedge clk) miso_s = miso;

    always @(posedge clk) begin
        int j, s;
        cyc++;
        if (rst) begin
            chk_en = 1;
            m_act  = 0;
            m_addr = '0;
            m_data = '0;
        end else if (m_act) begin
            if (m_c < (m_n + 1) * P) begin
                j = m_c % P;
                if (j == 0) begin
                    m_word = mem[m_c / P][7:0];
                    m_rx   = '0;
                end else if (j <= 16 * D) begin
                    s = j - 1;
                    // end of a low half-period: SCLK rises here
                    if ((s % D) == D - 1 && ((s / D) % 2) == 0)
                        m_rx = {m_rx[6:0], miso_s};
                end else begin
                    m_data = {24'b0, m_rx};
                end
                m_c++;
            end else begin
                m_act = 0;
            end
        end else if (start) begin
            m_act  = 1;
            m_c    = 0;
            m_n    = int'(ntx);
            m_addr = ntx;
            t0     = cyc;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [6:0]  e_ctl;
        logic [1:0]  e_addr;
        logic [31:0] e_data;
        int j, s;
        if (chk_en) begin
            // {sclk, mosi, cs_n, wr, busy, hold, done}
            e_ctl  = 7'b0010000;
            e_addr = m_addr;
            e_data = m_data;
            if (m_act) begin
                if (m_c == (m_n + 1) * P) begin
                    e_ctl = 7'b0010001;
                end else begin
                    j      = m_c % P;
                    e_addr = 2'(m_c / P);
                    e_ctl  = 7'b0000110;
                    if (j >= 1 && j <= 16 * D) begin
                        s = j - 1;
                        e_ctl[6] = ((s / D) % 2) == 1;
                        e_ctl[5] = m_word[7 - s / (2 * D)];
                    end else if (j == P - 1) begin
                        e_ctl[3] = 1'b1;
                        e_data   = {24'b0, m_rx};
                    end
                end
            end
            check("ctl{sclk,mosi,cs_n,wr,busy,hold,done}",
                  {25'b0, sclk, mosi, cs_n, wr, busy, hold, done}, {25'b0, e_ctl});
            check("addr_o", {30'b0, addr}, {30'b0, e_addr});
            check("data_o", data_o, e_data);
        end
    end

    // ---------------- event monitor ----------------
    int          n_done = 0, n_wr = 0, n_rise = 0, cs_bad = 0, done_lat = -1;
    logic [15:0] mosi_bits = '0;
    logic        sclk_prev = 1'b0;
    logic [1:0]  wa [$];
    logic [31:0] wd [$];

    always @(negedge clk) begin
        if (sclk && !sclk_prev) begin
            n_rise++;
            mosi_bits = {mosi_bits[14:0], mosi};
        end
        sclk_prev = sclk;
        if (done === 1'b1) begin
            n_done++;
            done_lat = cyc - t0;
        end
        if (wr === 1'b1) begin
            n_wr++;
            wa.push_back(addr);
            wd.push_back(data_o);
        end
        if (busy === 1'b1 && cs_n === 1'b1) cs_bad++;
    end

    task automatic clear_mon();
        n_done = 0; n_wr = 0; n_rise = 0; cs_bad = 0; done_lat = -1;
        mosi_bits = '0;
        wa.delete(); wd.delete();
    endtask

    task automatic pulse_start(input logic [1:0] n, input int mode);
        @(posedge clk); #1;
        start = 1'b1; ntx = n; miso_mode = mode;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (n_done == 0 && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("done_seen_before_timeout", {31'b0, n_done > 0}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] wd1;
        logic [31:0] sc;
        int          lat1;

        mem[0] = '0; mem[1] = '0; mem[2] = '0; mem[3] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // reset values
        check("rst_cs_n", {31'b0, cs_n}, 32'd1);
        check("rst_sclk_mosi", {30'b0, sclk, mosi}, 32'd0);
        check("rst_wr_busy_hold_done", {28'b0, wr, busy, hold, done}, 32'd0);
        check("rst_addr", {30'b0, addr}, 32'd0);
        check("rst_data", data_o, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // loopback single word
        mem[0] = 32'h0000_0025;
        clear_mon();
        pulse_start(2'd0, 0);
        wait_done();
        check("lb_done_latency", done_lat, 32'd34);
        check("lb_done_count", n_done, 32'd1);
        check("lb_wr_count", n_wr, 32'd1);
        if (n_wr >= 1) begin
            check("lb_wr_addr", {30'b0, wa[0]}, 32'd0);
            check("lb_wr_data", wd[0], 32'h0000_0025);
        end
        check("lb_sclk_rises", n_rise, 32'd8);

        // miso high, two words
        mem[0] = 32'h0000_0012; mem[1] = 32'h0000_0034;
        clear_mon();
        pulse_start(2'd1, 1);
        wait_done();
        check("m1_mosi_bits", {16'b0, mosi_bits}, 32'h0000_1234);
        check("m1_wr_count", n_wr, 32'd2);
        if (n_wr >= 2) begin
            check("m1_wr_addr0", {30'b0, wa[0]}, 32'd0);
            check("m1_wr_data0", wd[0], 32'h0000_00FF);
            check("m1_wr_addr1", {30'b0, wa[1]}, 32'd1);
            check("m1_wr_data1", wd[1], 32'h0000_00FF);
        end
        check("m1_cs_n_gap", cs_bad, 32'd0);
        check("m1_done_latency", done_lat, 32'd68);

        // full address range, random miso
        mem[0] = 32'hDEAD_BEA5; mem[1] = 32'h3C; mem[2] = 32'h81; mem[3] = 32'h7E;
        clear_mon();
        pulse_start(2'd3, 2);
        wait_done();
        check("full_wr_count", n_wr, 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < n_wr) check("full_wr_addr_order", {30'b0, wa[i]}, i);
        check("full_done_count", n_done, 32'd1);
        check("full_done_latency", done_lat, 32'd136);
        check("full_addr_no_wrap", {30'b0, addr}, 32'd3);

        // second start during SHIFT is ignored
        mem[0] = 32'h5A;
        clear_mon();
        pulse_start(2'd0, 0);
        repeat (10) @(posedge clk);
        #1 start = 1'b1; ntx = 2'd3;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        repeat (60) @(negedge clk);
        check("restart_done_latency", done_lat, 32'd34);
        check("restart_done_count", n_done, 32'd1);
        check("restart_wr_count", n_wr, 32'd1);

        // reset during the fifth bit
        clear_mon();
        pulse_start(2'd1, 0);
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_cs_n", {31'b0, cs_n}, 32'd1);
        check("abort_sclk", {31'b0, sclk}, 32'd0);
        check("abort_busy_hold", {30'b0, busy, hold}, 32'd0);
        repeat (80) @(negedge clk);
        check("abort_no_wr", n_wr, 32'd0);
        check("abort_no_done", n_done, 32'd0);

        // CLK_DIV = 1 instance
        mem[0] = 32'h96;
        @(posedge clk); #1 rst1 = 1'b0;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        wd1 = '0; sc = '0; lat1 = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (sclk1) sc[k] = 1'b1;
            if (wr1) wd1 = data_o1;
            if (done1 && lat1 < 0) lat1 = k;
        end
        check("div1_sclk_first", {28'b0, sc[1], sc[2], sc[3], sc[4]}, 32'b0101);
        check("div1_sclk_end", {30'b0, sc[16], sc[17]}, 32'b10);
        check("div1_done_latency", lat1, 32'd18);
        check("div1_wr_data", wd1, 32'h96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got time %0t, expected < 200000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
